usart_rx_fifo: RTL and testbench
================================

# usart_rx_fifo

Parametrised UART receiver with a first-word-fall-through receive FIFO, runtime-independent framing options fixed by parameters, and per-word error status. It sits between the board RX pin and the CPU-side peripheral bus and replaces the single-byte receiver. It adds:
- configurable data width, parity and stop bits;
- majority-vote sampling and false-start rejection;
- buffering with overrun detection.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first on the wire.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive entries, power of two, 2..64.

Ports:
- bit_clock_x16  in  1  oversample clock, 16× baud; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_pin  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  head-of-FIFO data, valid while available=1, else 0.
- frame_error  out  1  head entry had a low stop bit; valid while available=1.
- parity_error  out  1  head entry failed parity; always 0 when PARITY=0.
- available  out  1  FIFO non-empty.
- acknowledge  in  1  pop head; one pop per cycle held high.
- overrun  out  1  sticky; a completed frame was dropped because the FIFO was full.
- clear_overrun  in  1  clears overrun.

## Operation
- rx_pin passes through a 2-flop synchroniser. "Sample" means the majority of the last three synchronised values.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A 4-bit oversample counter and a bit counter (width for DATA_BITS) drive the transitions.
- IDLE: on synchronised low, counter←0 and go to START.
- START: at counter=7, if the sample is 1 it is a false start: return to IDLE and push nothing. If the sample is 0, counter←0 and go to DATA.
- DATA: at each counter=15, shift the sample in at the MSB of a DATA_BITS register (LSB-first reception). After DATA_BITS samples go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: at counter=15, capture the bit. Odd parity requires XOR(data,bit)=1; even parity requires 0.
- STOP: at counter=15, sample the stop bit.
  - If STOP_BITS=2, a second stop bit is sampled 16 cycles later.
  - Any low stop sample sets the frame's frame_error.
  - Completing the last stop sample pushes {parity_err, frame_err, data}.
  - Then go to IDLE if the sample was 1, or to WAIT_HIGH if it was 0.
- WAIT_HIGH: stay until the synchronised input is 1, then go to IDLE. A break or stuck-low line therefore yields exactly one entry.
- Errored frames are still pushed; software inspects the flags.
- FIFO full at push time: drop the frame and set overrun. The FIFO contents are unchanged.
- Push and pop in the same cycle: both happen, including when the FIFO is full (the push is accepted, no overrun) and when it is empty (push only, since the pop is ignored).
- acknowledge while empty is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around; full = MSBs differ and the remaining bits are equal.
- clear_overrun and an overrun event in the same cycle: overrun stays 1.

## Timing
- Asynchronous reset, in effect while reset_n=0:
  - state=IDLE, counters=0, FIFO empty;
  - available=0, data_out=0, frame_error=0, parity_error=0, overrun=0;
  - synchroniser flops=1.
- Reset mid-frame aborts the frame with nothing pushed.
- The push occurs on the clock edge of the final stop-bit sample. available/data_out/flags update on the next edge, so the outputs are registered and visible one cycle after the push.
- Pop: on the edge where acknowledge=1 and available=1, the next entry (or 0s with available=0) appears after that edge.
- Wire-to-sample latency: 2 synchroniser cycles plus majority filter. The start is confirmed 8 cycles after the synchronised falling edge, and each bit is sampled every 16 cycles after that.

## Test plan
- Defaults, send 0xA5 (8N1, clean): available rises after the stop bit; data_out=0xA5, frame_error=0, parity_error=0; acknowledge → available=0, data_out=0.
- 3-cycle low glitch while idle: no push; state returns to IDLE; the next frame 0x3C is received correctly.
- PARITY=2, DATA_BITS=7: send 0x41 with wrong parity bit 1 → parity_error=1, data_out=0x41. Resend with parity 0 → parity_error=0.
- Stop bit driven low for 0x55, line held low for 40 bit times: exactly one entry (data_out=0x55, frame_error=1); no further entry until the line goes high and a new start bit arrives.
- FIFO_DEPTH=4: send 5 frames 0x01..0x05 without acknowledge → overrun=1 and the FIFO holds 0x01..0x04. Pop four times and check the order; clear_overrun → overrun=0.
- Assert reset_n=0 mid-DATA of 0xFF, release, send 0x12 → exactly one entry, 0x12.

Source files
------------

// File: rtl/usart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote sampling, false-start rejection
// and a first-word-fall-through receive FIFO carrying per-word frame/parity status.
module usart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 bit_clock_x16,
  input  logic                 reset_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 available,
  input  logic                 acknowledge,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int BCW = $clog2(DATA_BITS);
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [1:0]           hist_q;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]        head_q, head_d;
  logic                 avail_q, avail_d;
  logic                 overrun_q, overrun_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic          sample, push, pop, full, do_push;
  logic [EW-1:0] entry;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1) return ~(^d ^ p);
    else if (PARITY == 2) return ^d ^ p;
    else return 1'b0;
  endfunction

  assign sample = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q + 4'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    push       = 1'b0;
    entry      = {parity_err(shift_q, par_bit_q), ferr_q | ~sample, shift_q};
    case (state_q)
      S_IDLE: begin
        os_cnt_d   = 4'd0;
        bit_cnt_d  = '0;
        ferr_d     = 1'b0;
        stop_cnt_d = 1'b0;
        if (!sync2_q) state_d = S_START;
      end
      S_START: begin
        if (os_cnt_q == 4'd7) begin
          if (sample) state_d = S_IDLE;
          else begin
            os_cnt_d = 4'd0;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (os_cnt_q == 4'd15) begin
          shift_d   = {sample, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(DATA_BITS - 1))
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (os_cnt_q == 4'd15) begin
          par_bit_d = sample;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (os_cnt_q == 4'd15) begin
          ferr_d = ferr_q | ~sample;
          if (STOP_BITS == 2 && !stop_cnt_q) stop_cnt_d = 1'b1;
          else begin
            push    = 1'b1;
            state_d = sample ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        os_cnt_d = 4'd0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the head as it stands after this edge's pop;
  // a word pushed on this edge therefore appears one edge later.
  always_comb begin
    pop       = acknowledge & avail_q;
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push   = push & (~full | pop);
    wr_ptr_d  = wr_ptr_q + PW'(do_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    overrun_d = (push & full & ~pop) | (overrun_q & ~clear_overrun);
    head_d    = '0;
    avail_d   = 1'b0;
    if (rd_ptr_d != wr_ptr_q) begin
      head_d  = mem_q[rd_ptr_d[AW-1:0]];
      avail_d = 1'b1;
    end
  end

  always_ff @(posedge bit_clock_x16 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 2'b11;
      state_q    <= S_IDLE;
      os_cnt_q   <= 4'd0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      avail_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= rx_pin;
      sync2_q    <= sync1_q;
      hist_q     <= {hist_q[0], sync2_q};
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      avail_q    <= avail_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge bit_clock_x16) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end

  assign data_out     = head_q[DATA_BITS-1:0];
  assign frame_error  = head_q[DATA_BITS];
  assign parity_error = head_q[DATA_BITS+1];
  assign available    = avail_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Bench for usart_rx_fifo: an 8N1 depth-4 instance and a 7E2 depth-2 instance,
// checked every cycle against expected-word queues built from the transmitted bits.
module tb_usart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rx0, rx1, ack0, ack1, clr0, clr1;
  logic [7:0] dout0;
  logic [6:0] dout1;
  logic fe0, pe0, av0, ov0, fe1, pe1, av1, ov1;

  usart_rx_fifo dut0 (
    .bit_clock_x16(clk), .reset_n(reset_n), .rx_pin(rx0), .data_out(dout0),
    .frame_error(fe0), .parity_error(pe0), .available(av0), .acknowledge(ack0),
    .overrun(ov0), .clear_overrun(clr0)
  );

  usart_rx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) dut1 (
    .bit_clock_x16(clk), .reset_n(reset_n), .rx_pin(rx1), .data_out(dout1),
    .frame_error(fe1), .parity_error(pe1), .available(av1), .acknowledge(ack1),
    .overrun(ov1), .clear_overrun(clr1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected words: {parity_err, frame_err, data[8:0]}
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic        ovr_exp0 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("dut0 unexpected available", {31'd0, av0 && q0.size() == 0}, 32'd0);
      if (av0 && q0.size() != 0) begin
        chk("dut0 head word", {21'd0, pe0, fe0, 1'b0, dout0}, {21'd0, q0[0]});
        if (ack0) void'(q0.pop_front());
      end
      if (!av0) chk("dut0 empty outputs", {22'd0, pe0, fe0, dout0}, 32'd0);
      chk("dut1 unexpected available", {31'd0, av1 && q1.size() == 0}, 32'd0);
      if (av1 && q1.size() != 0) begin
        chk("dut1 head word", {21'd0, pe1, fe1, 2'b00, dout1}, {21'd0, q1[0]});
        if (ack1) void'(q1.pop_front());
      end
      if (!av1) chk("dut1 empty outputs", {23'd0, pe1, fe1, dout1}, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input int inst, input logic b);
    if (inst == 0) rx0 = b;
    else rx1 = b;
    idle(16);
  endtask

  task automatic model_push(input int inst, input logic [10:0] e);
    if (inst == 0) begin
      if (q0.size() == 4) ovr_exp0 = 1'b1;
      else q0.push_back(e);
    end else if (q1.size() < 2) begin
      q1.push_back(e);
    end
  endtask

  // Instance 0 is 8N1; instance 1 is 7 data bits, even parity, 2 stop bits.
  task automatic send_frame(input int inst, input logic [8:0] d, input logic pbit,
                            input logic stop_a, input logic stop_b);
    logic ferr, perr;
    int nb;
    nb   = (inst == 0) ? 8 : 7;
    ferr = (inst == 0) ? !stop_a : (!stop_a || !stop_b);
    perr = (inst == 0) ? 1'b0 : ((^d[6:0]) ^ pbit);
    drive(inst, 1'b0);
    for (int i = 0; i < nb; i++) drive(inst, d[i]);
    if (inst == 0) begin
      model_push(0, {perr, ferr, d});
      drive(0, stop_a);
    end else begin
      drive(1, pbit);
      drive(1, stop_a);
      model_push(1, {perr, ferr, d});
      drive(1, stop_b);
    end
  endtask

  task automatic pop_chk(input int inst, input logic [8:0] d, input logic fe, input logic pe);
    int w;
    w = 0;
    while (!(inst == 0 ? av0 : av1) && w < 400) begin
      idle(1);
      w++;
    end
    if (inst == 0) begin
      chk("dut0 available before pop", {31'd0, av0}, 32'd1);
      chk("dut0 data_out", {24'd0, dout0}, {23'd0, d});
      chk("dut0 frame_error", {31'd0, fe0}, {31'd0, fe});
      chk("dut0 parity_error", {31'd0, pe0}, {31'd0, pe});
      ack0 = 1'b1;
      idle(1);
      ack0 = 1'b0;
    end else begin
      chk("dut1 available before pop", {31'd0, av1}, 32'd1);
      chk("dut1 data_out", {25'd0, dout1}, {23'd0, d});
      chk("dut1 frame_error", {31'd0, fe1}, {31'd0, fe});
      chk("dut1 parity_error", {31'd0, pe1}, {31'd0, pe});
      ack1 = 1'b1;
      idle(1);
      ack1 = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1;
    ack0 = 1'b0; ack1 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    idle(3);
    chk("reset available", {30'd0, av0, av1}, 32'd0);
    chk("reset data_out", {17'd0, dout1, dout0}, 32'd0);
    chk("reset flags", {26'd0, fe0, pe0, ov0, fe1, pe1, ov1}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    // Clean 8N1 frame
    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    idle(4);
    pop_chk(0, 9'h0A5, 1'b0, 1'b0);
    chk("available after pop", {31'd0, av0}, 32'd0);
    chk("data_out after pop", {24'd0, dout0}, 32'd0);

    // Short low glitch must be rejected as a false start
    rx0 = 1'b0;
    idle(3);
    rx0 = 1'b1;
    idle(40);
    chk("glitch no push", {31'd0, av0}, 32'd0);
    send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1);
    pop_chk(0, 9'h03C, 1'b0, 1'b0);

    // Even parity, 7 data bits, 2 stop bits
    send_frame(1, 9'h041, 1'b1, 1'b1, 1'b1);
    pop_chk(1, 9'h041, 1'b0, 1'b1);
    send_frame(1, 9'h041, 1'b0, 1'b1, 1'b1);
    pop_chk(1, 9'h041, 1'b0, 1'b0);
    send_frame(1, 9'h02A, 1'b1, 1'b1, 1'b0);
    rx1 = 1'b1;
    pop_chk(1, 9'h02A, 1'b1, 1'b0);

    // Break: low stop bit then line held low for 40 bit times
    send_frame(0, 9'h055, 1'b0, 1'b0, 1'b1);
    idle(640);
    pop_chk(0, 9'h055, 1'b1, 1'b0);
    idle(64);
    chk("break single entry", {31'd0, av0}, 32'd0);
    rx0 = 1'b1;
    idle(64);
    chk("break no entry on release", {31'd0, av0}, 32'd0);
    send_frame(0, 9'h066, 1'b0, 1'b1, 1'b1);
    pop_chk(0, 9'h066, 1'b0, 1'b0);

    // Overrun on the fifth unread frame
    for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 1'b0, 1'b1, 1'b1);
    chk("no overrun when just full", {31'd0, ov0}, 32'd0);
    send_frame(0, 9'h005, 1'b0, 1'b1, 1'b1);
    idle(8);
    chk("overrun set", {31'd0, ov0}, 32'd1);
    chk("overrun vs model", {31'd0, ov0}, {31'd0, ovr_exp0});
    for (int i = 1; i <= 4; i++) pop_chk(0, 9'(i), 1'b0, 1'b0);
    chk("empty after drain", {31'd0, av0}, 32'd0);
    chk("overrun sticky", {31'd0, ov0}, 32'd1);
    clr0 = 1'b1;
    idle(1);
    clr0 = 1'b0;
    ovr_exp0 = 1'b0;
    chk("overrun cleared", {31'd0, ov0}, 32'd0);

    // Reset in the middle of a 0xFF frame
    drive(0, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 1'b1);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    idle(3);
    chk("mid-frame reset available", {31'd0, av0}, 32'd0);
    reset_n = 1'b1;
    idle(32);
    send_frame(0, 9'h012, 1'b0, 1'b1, 1'b1);
    idle(4);
    pop_chk(0, 9'h012, 1'b0, 1'b0);
    idle(200);
    chk("single entry after reset", {31'd0, av0}, 32'd0);
    chk("dut1 idle at end", {31'd0, av1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
